// File: rtl/msdap_frame_rx_if.sv
// Purpose: bundles the serial-side controls and the word-side valid/ready bus of msdap_frame_rx.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the core stalls the FIFO head; InReady tells the sender there is room.
// Ports: Enable/Frame/Input (serial side), InReady, out_valid/out_data/out_ready (word side),
//        overflow/frame_error (sticky status). The slave modport is the receiver's view, master the environment's.
interface msdap_frame_rx_if #(
    parameter int CHANNELS = 2,
    parameter int WORD_W   = 16
);
    logic                         Enable;
    logic                         Frame;
    logic [CHANNELS-1:0]          Input;
    logic                         InReady;
    logic                         out_valid;
    logic [CHANNELS*WORD_W-1:0]   out_data;
    logic                         out_ready;
    logic                         overflow;
    logic                         frame_error;

    modport slave (
        input  Enable, Frame, Input, out_ready,
        output InReady, out_valid, out_data, overflow, frame_error
    );

    modport master (
        output Enable, Frame, Input, out_ready,
        input  InReady, out_valid, out_data, overflow, frame_error
    );
endinterface

// File: rtl/msdap_frame_rx.sv
// Purpose: deserialises one WORD_W-bit word per channel per Frame pulse and queues complete frames.
// Latency: word visible on out_valid/out_data the cycle after its last serial bit is sampled.
// Backpressure: out_ready pops the head; a frame arriving with the FIFO full and no pop is dropped (overflow).
// Ports: Dclk (clock), Reset (sync, active high), bus (msdap_frame_rx_if.slave: Enable, Frame, Input,
//        InReady, out_valid, out_data, out_ready, overflow, frame_error).
module msdap_frame_rx #(
    parameter int CHANNELS   = 2,
    parameter int WORD_W     = 16,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Dclk,
    input  logic              Reset,
    msdap_frame_rx_if.slave   bus
);
    localparam int BW = $clog2(WORD_W);
    localparam int DW = CHANNELS * WORD_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [BW-1:0]     bitcnt;
    logic [WORD_W-1:0] shiftReg  [CHANNELS];
    logic [WORD_W-1:0] shiftNext [CHANNELS];
    logic [DW-1:0]     wordNext;
    logic              frameErrQ;

    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
    logic              overflowQ;
    logic              inReadyQ;

    logic inWord;
    logic sampleBit;
    logic earlyFrame;
    logic wordDone;
    logic fifoFull;
    logic popEn;
    logic pushEn;

    // Every sampled bit goes through the same shift; stale bits from an abandoned
    // word are pushed out before the next word completes, so no clear is needed.
    always_comb begin
        wordNext = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MSB_FIRST != 0) begin
                shiftNext[c] = {shiftReg[c][WORD_W-2:0], bus.Input[c]};
            end else begin
                shiftNext[c] = {bus.Input[c], shiftReg[c][WORD_W-1:1]};
            end
            wordNext[c*WORD_W +: WORD_W] = shiftNext[c];
        end
    end

    assign inWord     = (state == SHIFT);
    assign sampleBit  = bus.Enable & (bus.Frame | inWord);
    assign earlyFrame = bus.Enable & bus.Frame & inWord;
    assign wordDone   = bus.Enable & ~bus.Frame & inWord & (bitcnt == LAST_BIT);

    // Framing FSM: a Frame always restarts at bit 0, whether from IDLE or mid-word.
    always_ff @(posedge Dclk) begin
        if (Reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            frameErrQ <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shiftReg[c] <= '0;
            end
        end else begin
            if (sampleBit) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    shiftReg[c] <= shiftNext[c];
                end
            end
            if (earlyFrame) begin
                frameErrQ <= 1'b1;
            end
            if (!bus.Enable) begin
                state  <= IDLE;
                bitcnt <= '0;
            end else if (bus.Frame) begin
                state  <= SHIFT;
                bitcnt <= BW'(1);
            end else if (inWord) begin
                if (wordDone) begin
                    state  <= IDLE;
                    bitcnt <= '0;
                end else begin
                    bitcnt <= bitcnt + BW'(1);
                end
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign fifoFull  = (count == DEPTH_C);
    assign popEn     = (count != '0) & bus.out_ready;
    assign pushEn    = wordDone & (~fifoFull | popEn);
    assign countNext = count + CW'(pushEn) - CW'(popEn);

    always_ff @(posedge Dclk) begin
        if (Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflowQ <= 1'b0;
            inReadyQ  <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= countNext;
            if (wordDone & fifoFull & ~popEn) begin
                overflowQ <= 1'b1;
            end
            inReadyQ <= bus.Enable & (countNext < DEPTH_C);
        end
    end

    always_ff @(posedge Dclk) begin
        if (pushEn) begin
            mem[wrPtr] <= wordNext;
        end
    end

    // Gating with out_valid keeps out_data at zero when empty, including right after reset.
    assign bus.out_valid   = (count != '0);
    assign bus.out_data    = bus.out_valid ? mem[rdPtr] : '0;
    assign bus.InReady     = inReadyQ;
    assign bus.overflow    = overflowQ;
    assign bus.frame_error = frameErrQ;
endmodule
